// File: rtl/device_sync_unit.sv
// Device-bus synchronisation peripheral: ownership-checked mutex bank with
// per-core bulk release, plus a show-ahead console FIFO with sticky overflow.
`timescale 1ns/1ps
module device_sync_unit #(
  parameter int NUM_CORES     = 16,
  parameter int CORE_ID_WIDTH = $clog2(NUM_CORES),
  parameter int NUM_MUTEXES   = 8,
  parameter int MUTEX_BASE    = 'h3e0,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CORE_ID_WIDTH-1:0] device_core_id,
  input  logic                     device_write_en,
  input  logic                     device_read_en,
  input  logic [9:0]               device_addr,
  input  logic [15:0]              device_data_out,
  output logic [15:0]              device_data_in,
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic [CORE_ID_WIDTH-1:0] output_core_id,
  output logic [15:0]              output_data_val
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = CORE_ID_WIDTH + 16;
  localparam logic [9:0] MB           = 10'(MUTEX_BASE);
  localparam logic [9:0] ADDR_CONSOLE = 10'h3ff;
  localparam logic [9:0] ADDR_STATUS  = 10'h3fe;
  localparam logic [9:0] ADDR_RELALL  = 10'h3fd;

  logic                     held_q   [NUM_MUTEXES];
  logic                     held_d   [NUM_MUTEXES];
  logic [CORE_ID_WIDTH-1:0] holder_q [NUM_MUTEXES];
  logic [CORE_ID_WIDTH-1:0] holder_d [NUM_MUTEXES];
  logic [NUM_MUTEXES-1:0]   mutex_hit;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   data_in_q, data_in_d;
  logic [15:0]   rdata;

  logic console_wr, status_wr, relall_wr, do_read;
  logic full, empty, push, pop;
  logic [EW-1:0] head;

  // A write wins over a simultaneous read; the read is then ignored.
  assign do_read    = device_read_en && !device_write_en;
  assign console_wr = device_write_en && (device_addr == ADDR_CONSOLE);
  assign status_wr  = device_write_en && (device_addr == ADDR_STATUS);
  assign relall_wr  = device_write_en && (device_addr == ADDR_RELALL);

  always_comb begin
    for (int i = 0; i < NUM_MUTEXES; i++) begin
      mutex_hit[i] = (device_addr == MB + 10'(i));
    end
  end

  always_comb begin
    held_d   = held_q;
    holder_d = holder_q;
    for (int i = 0; i < NUM_MUTEXES; i++) begin
      if (device_write_en && mutex_hit[i]) begin
        if (device_data_out != 16'h0000) begin
          if (!held_q[i]) begin
            held_d[i]   = 1'b1;
            holder_d[i] = device_core_id;
          end
        end else if (held_q[i] && holder_q[i] == device_core_id) begin
          held_d[i] = 1'b0;
        end
      end else if (relall_wr && held_q[i] && holder_q[i] == device_core_id) begin
        held_d[i] = 1'b0;
      end
    end
  end

  // Console handshake: the head entry is offered while output_valid is high
  // and is consumed on any clock edge where output_valid && output_ready.
  // A full FIFO still accepts a push in the same cycle as a pop.
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && output_ready;
  assign push  = console_wr && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (console_wr && !push) overflow_d = 1'b1;
    else if (status_wr)      overflow_d = 1'b0;
  end

  // Read data reflects state before any same-cycle update.
  always_comb begin
    rdata = '0;
    if (device_addr == ADDR_CONSOLE) begin
      rdata = 16'(count_q);
    end else if (device_addr == ADDR_STATUS) begin
      rdata[0]    = overflow_q;
      rdata[1]    = full;
      rdata[2]    = empty;
      rdata[15:8] = 8'(count_q);
    end else begin
      for (int i = 0; i < NUM_MUTEXES; i++) begin
        if (mutex_hit[i]) begin
          rdata[0] = held_q[i] && (holder_q[i] == device_core_id);
          rdata[1] = held_q[i];
          if (held_q[i]) rdata[4 +: CORE_ID_WIDTH] = holder_q[i];
        end
      end
    end
  end

  assign data_in_d = do_read ? rdata : data_in_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q     <= '{default: '0};
      holder_q   <= '{default: '0};
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      data_in_q  <= '0;
    end else begin
      held_q     <= held_d;
      holder_q   <= holder_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      data_in_q  <= data_in_d;
      if (push) mem_q[wr_ptr_q] <= {device_core_id, device_data_out};
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign device_data_in  = data_in_q;
  assign output_valid    = !empty;
  assign output_core_id  = head[EW-1:16];
  assign output_data_val = head[15:0];

endmodule

// File: tb/tb_device_sync_unit.sv
// Directed bench for device_sync_unit: vector table for mutex/register access,
// hand sequences with an expected-entry queue for the console FIFO.
`timescale 1ns/1ps
module tb_device_sync_unit;

  localparam int DEPTH = 8;
  localparam logic [9:0] MB = 10'h3e0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  device_core_id = '0;
  logic        device_write_en = 1'b0;
  logic        device_read_en = 1'b0;
  logic [9:0]  device_addr = '0;
  logic [15:0] device_data_out = '0;
  logic [15:0] device_data_in;
  logic        output_valid;
  logic        output_ready = 1'b0;
  logic [3:0]  output_core_id;
  logic [15:0] output_data_val;

  device_sync_unit dut (
    .clk             (clk),
    .reset           (reset),
    .device_core_id  (device_core_id),
    .device_write_en (device_write_en),
    .device_read_en  (device_read_en),
    .device_addr     (device_addr),
    .device_data_out (device_data_out),
    .device_data_in  (device_data_in),
    .output_valid    (output_valid),
    .output_ready    (output_ready),
    .output_core_id  (output_core_id),
    .output_data_val (output_data_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [3:0]  core;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic        chk;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        ovf_m = 1'b0;

  function automatic vec_t v(input logic we, input logic re, input logic [3:0] core,
                             input logic [9:0] addr, input logic [15:0] wd,
                             input logic chk, input logic [15:0] exp_rd);
    vec_t r;
    r.we = we; r.re = re; r.core = core; r.addr = addr; r.wdata = wd;
    r.chk = chk; r.exp_rd = exp_rd;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [3:0] core,
                       input logic [9:0] addr, input logic [15:0] wd);
    device_write_en = we;
    device_read_en  = re;
    device_core_id  = core;
    device_addr     = addr;
    device_data_out = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 10'd0, 16'd0);
  endtask

  task automatic do_read(input string name, input logic [3:0] core,
                         input logic [9:0] addr, input logic [15:0] exp);
    drive(1'b0, 1'b1, core, addr, 16'd0);
    step();
    idle();
    check(name, 32'(device_data_in), 32'(exp));
  endtask

  task automatic do_write(input logic [3:0] core, input logic [9:0] addr, input logic [15:0] wd);
    drive(1'b1, 1'b0, core, addr, wd);
    step();
    idle();
  endtask

  // Model of one console write, including a same-cycle pop when ready is high.
  task automatic console_write(input logic [3:0] core, input logic [15:0] wd);
    logic pop_now;
    pop_now = (exp_q.size() != 0) && output_ready;
    if (exp_q.size() < DEPTH || pop_now) begin
      if (pop_now) void'(exp_q.pop_front());
      exp_q.push_back({core, wd});
    end else begin
      ovf_m = 1'b1;
    end
    do_write(core, 10'h3ff, wd);
  endtask

  task automatic drain(input string name);
    idle();
    output_ready = 1'b1;
    for (int k = 0; k < DEPTH + 2 && exp_q.size() != 0; k++) begin
      check({name, "_valid"}, 32'(output_valid), 32'd1);
      check({name, "_head"}, 32'({output_core_id, output_data_val}), 32'(exp_q[0]));
      step();
      void'(exp_q.pop_front());
    end
    output_ready = 1'b0;
    check({name, "_empty"}, 32'(output_valid), 32'd0);
  endtask

  initial begin
    // Mutex and register-access vectors, one cycle each.
    vecs.push_back(v(0, 1, 4'd3,  MB + 10'd0, 16'd0, 1, 16'h0000));
    vecs.push_back(v(1, 0, 4'd2,  MB + 10'd5, 16'd1, 0, 16'h0000));
    vecs.push_back(v(1, 0, 4'd7,  MB + 10'd5, 16'd1, 0, 16'h0000));
    vecs.push_back(v(0, 1, 4'd7,  MB + 10'd5, 16'd0, 1, 16'h0022));
    vecs.push_back(v(0, 1, 4'd2,  MB + 10'd5, 16'd0, 1, 16'h0023));
    vecs.push_back(v(1, 0, 4'd7,  MB + 10'd5, 16'd0, 0, 16'h0000));
    vecs.push_back(v(0, 1, 4'd2,  MB + 10'd5, 16'd0, 1, 16'h0023));
    vecs.push_back(v(1, 0, 4'd2,  MB + 10'd5, 16'h5, 0, 16'h0000));
    vecs.push_back(v(0, 1, 4'd7,  MB + 10'd5, 16'd0, 1, 16'h0022));
    vecs.push_back(v(1, 0, 4'd2,  MB + 10'd5, 16'd0, 0, 16'h0000));
    vecs.push_back(v(0, 1, 4'd2,  MB + 10'd5, 16'd0, 1, 16'h0000));
    vecs.push_back(v(1, 0, 4'd15, MB + 10'd6, 16'd9, 0, 16'h0000));
    vecs.push_back(v(0, 1, 4'd15, MB + 10'd6, 16'd0, 1, 16'h00f3));
    vecs.push_back(v(1, 0, 4'd4,  MB + 10'd0, 16'd1, 0, 16'h0000));
    vecs.push_back(v(1, 0, 4'd4,  MB + 10'd3, 16'd1, 0, 16'h0000));
    vecs.push_back(v(1, 0, 4'd4,  MB + 10'd7, 16'd1, 0, 16'h0000));
    vecs.push_back(v(1, 0, 4'd1,  MB + 10'd1, 16'd1, 0, 16'h0000));
    vecs.push_back(v(0, 1, 4'd4,  MB + 10'd3, 16'd0, 1, 16'h0043));
    vecs.push_back(v(1, 0, 4'd4,  10'h3fd,    16'd0, 0, 16'h0000));
    vecs.push_back(v(0, 1, 4'd4,  MB + 10'd0, 16'd0, 1, 16'h0000));
    vecs.push_back(v(0, 1, 4'd4,  MB + 10'd3, 16'd0, 1, 16'h0000));
    vecs.push_back(v(0, 1, 4'd4,  MB + 10'd7, 16'd0, 1, 16'h0000));
    vecs.push_back(v(0, 1, 4'd4,  MB + 10'd1, 16'd0, 1, 16'h0012));
    vecs.push_back(v(0, 1, 4'd1,  MB + 10'd1, 16'd0, 1, 16'h0013));
    vecs.push_back(v(0, 0, 4'd0,  10'd0,      16'd0, 1, 16'h0013));
    vecs.push_back(v(0, 1, 4'd1,  MB + 10'd8, 16'd0, 1, 16'h0000));
    vecs.push_back(v(0, 1, 4'd15, MB + 10'd6, 16'd0, 1, 16'h00f3));
    vecs.push_back(v(0, 1, 4'd0,  10'h3fd,    16'd0, 1, 16'h0000));
    vecs.push_back(v(0, 1, 4'd1,  MB + 10'd1, 16'd0, 1, 16'h0013));
    vecs.push_back(v(1, 1, 4'd1,  MB + 10'd1, 16'd0, 1, 16'h0013));
    vecs.push_back(v(0, 1, 4'd1,  MB + 10'd1, 16'd0, 1, 16'h0000));
    vecs.push_back(v(0, 1, 4'd0,  10'h3fe,    16'd0, 1, 16'h0004));
    vecs.push_back(v(0, 1, 4'd0,  10'h3ff,    16'd0, 1, 16'h0000));

    // Reset state.
    step();
    check("rst_data_in", 32'(device_data_in), 32'd0);
    check("rst_valid", 32'(output_valid), 32'd0);
    check("rst_core_id", 32'(output_core_id), 32'd0);
    check("rst_data_val", 32'(output_data_val), 32'd0);
    step();
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].re, vecs[i].core, vecs[i].addr, vecs[i].wdata);
      step();
      if (vecs[i].chk) check($sformatf("vec%0d_rd", i), 32'(device_data_in), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_valid", i), 32'(output_valid), 32'd0);
    end
    idle();

    // Overflow: DEPTH+1 writes with consumer stalled.
    for (int i = 1; i <= DEPTH + 1; i++) begin
      console_write(4'(i + 2), 16'(i));
      if (i == 1) begin
        check("first_push_valid", 32'(output_valid), 32'd1);
        check("first_push_head", 32'({output_core_id, output_data_val}), 32'({4'd3, 16'd1}));
      end
    end
    check("ovf_model", 32'(ovf_m), 32'd1);
    do_read("ovf_status", 4'd0, 10'h3fe, 16'h0803);
    do_read("ovf_count", 4'd0, 10'h3ff, 16'h0008);
    drain("drain1");
    do_read("drained_status", 4'd0, 10'h3fe, 16'h0005);
    do_write(4'd0, 10'h3fe, 16'h1234);
    ovf_m = 1'b0;
    do_read("ovf_cleared", 4'd0, 10'h3fe, 16'h0004);

    // Push into a full FIFO in the same cycle as a pop.
    for (int i = 1; i <= DEPTH; i++) console_write(4'(i), 16'h0100 + 16'(i));
    do_read("full_status", 4'd0, 10'h3fe, 16'h0802);
    output_ready = 1'b1;
    console_write(4'd9, 16'hbeef);
    output_ready = 1'b0;
    do_read("pushpop_status", 4'd0, 10'h3fe, 16'h0802);
    drain("drain2");

    // Asynchronous reset mid-operation.
    console_write(4'd3, 16'h1234);
    do_write(4'd3, MB + 10'd2, 16'd1);
    do_read("pre_rst_mutex", 4'd3, MB + 10'd2, 16'h0033);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(output_valid), 32'd0);
    check("async_rst_head", 32'({output_core_id, output_data_val}), 32'd0);
    check("async_rst_data_in", 32'(device_data_in), 32'd0);
    exp_q.delete();
    #3 reset = 1'b0;
    step();
    do_read("post_rst_mutex", 4'd3, MB + 10'd2, 16'h0000);
    do_read("post_rst_status", 4'd0, 10'h3fe, 16'h0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 ns");
    $fatal(1);
  end

endmodule
